// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute-stage ALU and its arbiter.
//   OP_W          : width of the one-hot ALU op vector
//   OP_ADD..OP_SRA: bit index of each operation inside the op vector
//   op_is_onehot  : true when exactly one op bit is set
package alu_pkg;

  localparam int OP_W    = 10;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_OR   = 5;
  localparam int OP_XOR  = 6;
  localparam int OP_SLL  = 7;
  localparam int OP_SRL  = 8;
  localparam int OP_SRA  = 9;

  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit was set.
  function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] low_cleared;
    low_cleared = op & (op - {{(OP_W-1){1'b0}}, 1'b1});
    return (op != '0) && (low_cleared == '0);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit integer ALU.
//   i_op  : one-hot op select (add,sub,slt,sltu,and,or,xor,sll,srl,sra)
//   i_a   : first operand
//   i_b   : second operand; shifts use i_b[4:0]
//   o_res : OR of the results of every selected op (0 when no op is selected)
//   o_err : op vector was not one-hot
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [31:0]     i_a,
  input  logic [31:0]     i_b,
  output logic [31:0]     o_res,
  output logic            o_err
);

  logic [31:0] w_each   [OP_W];
  logic [31:0] w_masked [OP_W];
  logic [4:0]  w_shamt;

  assign w_shamt = i_b[4:0];

  assign w_each[OP_ADD]  = i_a + i_b;
  assign w_each[OP_SUB]  = i_a - i_b;
  assign w_each[OP_SLT]  = {31'd0, ($signed(i_a) < $signed(i_b))};
  assign w_each[OP_SLTU] = {31'd0, (i_a < i_b)};
  assign w_each[OP_AND]  = i_a & i_b;
  assign w_each[OP_OR]   = i_a | i_b;
  assign w_each[OP_XOR]  = i_a ^ i_b;
  assign w_each[OP_SLL]  = i_a << w_shamt;
  assign w_each[OP_SRL]  = i_a >> w_shamt;
  assign w_each[OP_SRA]  = $signed(i_a) >>> w_shamt;

  // Malformed (multi-hot) ops still produce a defined value: the OR of all selected results.
  genvar gi;
  generate
    for (gi = 0; gi < OP_W; gi++) begin : g_mask
      assign w_masked[gi] = i_op[gi] ? w_each[gi] : 32'd0;
    end
  endgenerate

  always_comb begin
    o_res = 32'd0;
    for (int i = 0; i < OP_W; i++) begin
      o_res = o_res | w_masked[i];
    end
  end

  assign o_err = ~op_is_onehot(i_op);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with an optional fixed-priority bypass.
//   clk, rst   : clock and synchronous active-high reset
//   i_valid    : per-port request valid
//   i_can_acc  : downstream slot can take an op this cycle
//   o_grant    : index of the port selected this cycle
//   o_ready    : one-hot accept strobe (zero when nothing is accepted)
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_can_acc,
  output logic       o_grant,
  output logic [1:0] o_ready
);

  logic r_last_grant;
  logic w_grant;
  logic w_accept;

  always_comb begin
    if (FIXED_PRIO) begin
      w_grant = ~i_valid[0];
    end else if (&i_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = i_valid[1];
    end
  end

  assign w_accept = i_can_acc & i_valid[w_grant] & ~rst;
  assign o_ready  = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign o_grant  = w_grant;

  // Resetting to 1 makes port 0 the winner of the first contended cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters (port 0: EXU, port 1: AGU/CSR helper).
// Ops are accepted under round-robin arbitration and their result lands in a
// one-entry slot the following cycle; the slot holds until its owner consumes it.
//   clk, rst  : clock and synchronous active-high reset
//   req_valid / req_ready          : per-port request handshake
//   req_op/req_src1/req_src2/req_tag : {port1, port0} packed operands
//   rsp_valid / rsp_ready          : per-port response handshake
//   rsp_res, rsp_tag, rsp_err      : slot contents
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*OP_W-1:0]    req_op,
  input  logic [63:0]          req_src1,
  input  logic [63:0]          req_src2,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [31:0]          rsp_res,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_err
);

  logic             r_slot_full;
  logic             r_slot_owner;
  logic [31:0]      r_slot_res;
  logic [TAG_W-1:0] r_slot_tag;
  logic             r_slot_err;

  logic             w_drain;
  logic             w_can_acc;
  logic             w_accept;
  logic             w_grant;
  logic [OP_W-1:0]  w_op;
  logic [31:0]      w_src1;
  logic [31:0]      w_src2;
  logic [TAG_W-1:0] w_tag;
  logic [31:0]      w_alu_res;
  logic             w_alu_err;

  // Draining and accepting in the same cycle keeps one op per cycle under full load.
  assign w_drain   = r_slot_full & rsp_ready[r_slot_owner];
  assign w_can_acc = ~r_slot_full | w_drain;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (req_valid),
    .i_can_acc (w_can_acc),
    .o_grant   (w_grant),
    .o_ready   (req_ready)
  );

  assign w_accept = |req_ready;

  assign w_op   = w_grant ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
  assign w_src1 = w_grant ? req_src1[63:32]          : req_src1[31:0];
  assign w_src2 = w_grant ? req_src2[63:32]          : req_src2[31:0];
  assign w_tag  = w_grant ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

  alu_core u_alu (
    .i_op  (w_op),
    .i_a   (w_src1),
    .i_b   (w_src2),
    .o_res (w_alu_res),
    .o_err (w_alu_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_full  <= 1'b0;
      r_slot_owner <= 1'b0;
      r_slot_res   <= 32'd0;
      r_slot_tag   <= '0;
      r_slot_err   <= 1'b0;
    end else if (w_accept) begin
      r_slot_full  <= 1'b1;
      r_slot_owner <= w_grant;
      r_slot_res   <= w_alu_res;
      r_slot_tag   <= w_tag;
      r_slot_err   <= w_alu_err;
    end else if (w_drain) begin
      r_slot_full  <= 1'b0;
    end
  end

  // Masked during reset so no stale result is offered before the slot clears.
  assign rsp_valid = (r_slot_full & ~rst) ? {r_slot_owner, ~r_slot_owner} : 2'b00;
  assign rsp_res   = r_slot_res;
  assign rsp_tag   = r_slot_tag;
  assign rsp_err   = r_slot_err;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam logic [9:0] O_ADD  = 10'd1;
  localparam logic [9:0] O_SUB  = 10'd2;
  localparam logic [9:0] O_SLT  = 10'd4;
  localparam logic [9:0] O_SLTU = 10'd8;
  localparam logic [9:0] O_AND  = 10'd16;
  localparam logic [9:0] O_OR   = 10'd32;
  localparam logic [9:0] O_XOR  = 10'd64;
  localparam logic [9:0] O_SLL  = 10'd128;
  localparam logic [9:0] O_SRL  = 10'd256;
  localparam logic [9:0] O_SRA  = 10'd512;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [19:0] req_op;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [7:0]  req_tag;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  alu_arbiter #(.TAG_W(4), .FIXED_PRIO(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    logic [9:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[12];
  logic [31:0] pend_res[2];
  logic        pend_err[2];
  logic        m_last;
  int          acc_port;
  logic [1:0]  obs_ready;
  int          n_total;
  int          n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference ALU written from the operation definitions.
  function automatic void model_alu(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    logic [31:0] v[10];
    v[0] = a + b;
    v[1] = a - b;
    v[2] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    v[3] = (a < b) ? 32'd1 : 32'd0;
    v[4] = a & b;
    v[5] = a | b;
    v[6] = a ^ b;
    v[7] = a << b[4:0];
    v[8] = a >> b[4:0];
    v[9] = $unsigned($signed(a) >>> b[4:0]);
    r = 32'd0;
    for (int i = 0; i < 10; i++) if (op[i]) r = r | v[i];
    e = ($countones(op) != 1);
  endfunction

  task automatic present(input int p, input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] er, input logic ee);
    req_valid[p]         = 1'b1;
    req_op[p*10 +: 10]   = op;
    req_src1[p*32 +: 32] = a;
    req_src2[p*32 +: 32] = b;
    req_tag[p*4 +: 4]    = tag;
    pend_res[p]          = er;
    pend_err[p]          = ee;
  endtask

  task automatic present_model(input int p, input logic [9:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] tag);
    logic [31:0] r;
    logic        e;
    model_alu(op, a, b, r, e);
    present(p, op, a, b, tag, r, e);
  endtask

  task automatic present_random(input int p);
    logic [9:0] op;
    if ($urandom_range(0, 7) == 0) op = 10'($urandom_range(0, 1023));
    else op = 10'd1 << $urandom_range(0, 9);
    present_model(p, op, $urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  // One clock: checks at posedge-2, then advances to posedge+1 for new stimulus.
  task automatic step();
    logic       drain;
    logic       can_acc;
    logic       g;
    logic [1:0] exp_ready;
    exp_t       e;
    #7;
    drain = 1'b0;
    if (sb.size() > 0) begin
      e = sb[0];
      chk("rsp_valid", {30'd0, rsp_valid}, (e.port == 1) ? 32'd2 : 32'd1);
      chk("rsp_res", rsp_res, e.res);
      chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      drain = rsp_ready[e.port];
    end else begin
      chk("rsp_valid_idle", {30'd0, rsp_valid}, 32'd0);
    end
    can_acc = (sb.size() == 0) || drain;
    if (req_valid == 2'b11) g = ~m_last;
    else g = req_valid[1];
    exp_ready = (can_acc && req_valid[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
    obs_ready = req_ready;
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
    if (drain) begin
      $display("rsp port %0d res %h tag %h err %b", e.port, e.res, e.tag, e.err);
      void'(sb.pop_front());
    end
    acc_port = -1;
    if (exp_ready != 2'b00) begin
      e.port = int'(g);
      e.res  = pend_res[g];
      e.tag  = req_tag[int'(g)*4 +: 4];
      e.err  = pend_err[g];
      sb.push_back(e);
      m_last   = g;
      acc_port = int'(g);
      $display("req port %0d op %b tag %h", acc_port, req_op[acc_port*10 +: 10], e.tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    #7;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_last = 1'b1;
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    m_last  = 1'b1;
    rst = 1'b1; req_valid = 2'b00; req_op = '0; req_src1 = '0; req_src2 = '0;
    req_tag = '0; rsp_ready = 2'b00;
    pend_res[0] = 0; pend_res[1] = 0; pend_err[0] = 0; pend_err[1] = 0;

    vt[0]  = '{O_ADD,          32'd5,          32'd7,          32'd12,         1'b0};
    vt[1]  = '{O_SLTU,         32'd1,          32'hFFFFFFFF,   32'd1,          1'b0};
    vt[2]  = '{O_SLT,          32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vt[3]  = '{O_SRA,          32'h80000000,   32'd36,         32'hF8000000,   1'b0};
    vt[4]  = '{O_SLL,          32'd1,          32'd31,         32'h80000000,   1'b0};
    vt[5]  = '{10'd0,          32'd6,          32'd3,          32'd0,          1'b1};
    vt[6]  = '{O_ADD | O_OR,   32'd6,          32'd3,          32'h0000000F,   1'b1};
    vt[7]  = '{O_ADD,          32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vt[8]  = '{O_SRL,          32'h80000000,   32'd36,         32'h08000000,   1'b0};
    vt[9]  = '{O_SUB,          32'd0,          32'd1,          32'hFFFFFFFF,   1'b0};
    vt[10] = '{O_SLT,          32'hFFFFFFFF,   32'd1,          32'd1,          1'b0};
    vt[11] = '{O_XOR,          32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   1'b0};

    @(posedge clk);
    #1;
    reset_cycle();

    // Single port-0 add.
    rsp_ready = 2'b11;
    present(0, O_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
    step();
    chk("t1_accept", {30'd0, obs_ready}, 32'd1);
    req_valid = 2'b00;
    step();
    step();

    // Both ports streaming: alternate grants, one accept per cycle.
    reset_cycle();
    rsp_ready = 2'b11;
    present_random(0);
    present_random(1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_grant", {30'd0, obs_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
      if (acc_port >= 0) present_random(acc_port);
    end
    req_valid = 2'b00;
    step();
    step();

    // Backpressure holds the slot; release gives drain plus accept in one cycle.
    rsp_ready = 2'b00;
    present(0, O_SUB, 32'd3, 32'd5, 4'd5, 32'hFFFFFFFE, 1'b0);
    step();
    present_model(0, O_ADD, 32'd1, 32'd1, 4'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_ready", {30'd0, obs_ready}, 32'd0);
      chk("t3_held_res", rsp_res, 32'hFFFFFFFE);
    end
    rsp_ready = 2'b01;
    step();
    chk("t3_drain_accept", {30'd0, obs_ready}, 32'd1);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
    step();

    // Table vectors, alternating the issuing port.
    for (int i = 0; i < 12; i++) begin
      req_valid = 2'b00;
      present(i % 2, vt[i].op, vt[i].a, vt[i].b, 4'(i), vt[i].res, vt[i].err);
      step();
      chk("tbl_accept", {30'd0, obs_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
    end
    req_valid = 2'b00;
    step();
    step();

    // Reset while port 1 owns a full slot, then arbitration restarts at port 0.
    rsp_ready = 2'b00;
    present_model(1, O_XOR, 32'h1234, 32'h00FF, 4'd9);
    step();
    req_valid = 2'b00;
    step();
    reset_cycle();
    step();
    rsp_ready = 2'b11;
    present_random(0);
    present_random(1);
    step();
    chk("t6_first_grant", {30'd0, obs_ready}, 32'd1);
    req_valid = 2'b00;
    step();
    step();

    // Random traffic with random backpressure; ops held until accepted.
    for (int c = 0; c < 80; c++) begin
      rsp_ready = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] && $urandom_range(0, 2) != 0) present_random(p);
      end
      step();
      if (acc_port >= 0) req_valid[acc_port] = 1'b0;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
    step();
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
